// File: rtl/spi_rx.sv
// SPI mode-0 receive-only slave with a byte RX FIFO, exposed through a simple
// select/ready register bus (CTRL, STATUS, DATA) and a level interrupt.
module spi_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_cs_s1, r_cs_s2, r_cs_q;
  logic        r_sck_s1, r_sck_s2, r_sck_q;
  logic        r_mosi_s1, r_mosi_s2;
  logic        r_sel_q, r_ready, r_irq;
  logic [31:0] r_data_o;
  logic        r_req_pop, r_req_ctrl, r_req_stat;
  logic [2:0]  r_req_wd;
  logic        r_en, r_irqen, r_ovr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;

  logic        w_cs_fall, w_sck_rise, w_start, w_is_rd, w_is_wr;
  logic        w_push, w_pop, w_full, w_nempty, w_wr_en, w_ovr_set, w_ovr_clr;
  logic [7:0]  w_shift_nxt;
  logic [4:0]  w_count5;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{data_i[31:3], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_q    <= 1'b1;
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_q   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_cs_s1   <= spi_cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_q    <= r_cs_s2;
      r_sck_s1  <= spi_clk;
      r_sck_s2  <= r_sck_s1;
      r_sck_q   <= r_sck_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_cs_fall   = r_cs_q & ~r_cs_s2;
  assign w_sck_rise  = r_sck_s2 & ~r_sck_q;
  assign w_shift_nxt = {r_shift[6:0], r_mosi_s2};
  assign w_push      = (r_state == SHIFT) & ~r_cs_s2 & r_en & w_sck_rise & (r_bitcnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall && r_en) begin
          r_state  <= SHIFT;
          r_bitcnt <= '0;
          r_shift  <= '0;
        end
        SHIFT: if (r_cs_s2 || !r_en) begin
          r_state <= IDLE;
        end else if (w_sck_rise) begin
          r_shift  <= w_shift_nxt;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_start  = select & ~r_sel_q;
  assign w_is_rd  = (wstrb == 4'b0000);
  assign w_is_wr  = wstrb[0];
  assign w_nempty = (r_count != '0);
  assign w_full   = (r_count == LP_DEPTH);
  assign w_count5 = 5'(r_count);

  always_comb begin
    w_rdata = '0;
    case (addr[3:2])
      2'd0:    w_rdata[1:0] = {r_irqen, r_en};
      2'd1:    w_rdata[8:0] = {w_count5, 1'b0, r_ovr, w_full, w_nempty};
      2'd2:    w_rdata[7:0] = w_nempty ? r_mem[r_rptr] : 8'h00;
      default: w_rdata = '0;
    endcase
  end

  // Read data is captured at select's first cycle; the pop and register writes
  // are deferred to the ready cycle so their side effects line up with ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_q    <= 1'b0;
      r_ready    <= 1'b0;
      r_data_o   <= '0;
      r_req_pop  <= 1'b0;
      r_req_ctrl <= 1'b0;
      r_req_stat <= 1'b0;
      r_req_wd   <= '0;
    end else begin
      r_sel_q    <= select;
      r_ready    <= w_start;
      r_data_o   <= (w_start && w_is_rd) ? w_rdata : '0;
      r_req_pop  <= w_start & w_is_rd & (addr[3:2] == 2'd2) & w_nempty;
      r_req_ctrl <= w_start & w_is_wr & (addr[3:2] == 2'd0);
      r_req_stat <= w_start & w_is_wr & (addr[3:2] == 2'd1);
      r_req_wd   <= data_i[2:0];
    end
  end

  assign w_pop     = r_req_pop;
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_ovr_clr = r_req_stat & r_req_wd[2];

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) r_mem[r_wptr] <= w_shift_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
      r_en    <= 1'b0;
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovr <= w_ovr_set | (r_ovr & ~w_ovr_clr);
      if (r_req_ctrl) begin
        r_en    <= r_req_wd[0];
        r_irqen <= r_req_wd[1];
      end
      r_irq <= r_irqen & (w_nempty | r_ovr);
    end
  end

  assign ready  = r_ready;
  assign data_o = r_data_o;
  assign irq    = r_irq;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: register table, directed SPI/bus corner
// sequences, then random traffic against a queue-based reference model.
module tb_spi_rx;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, select, spi_cs, spi_clk, spi_mosi, ready, irq;
  logic [3:0]  wstrb, addr;
  logic [31:0] data_i, data_o;

  int n_checks = 0;
  int n_fail   = 0;

  spi_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .spi_cs(spi_cs),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  // Reference model state
  logic [7:0] mq[$];
  bit m_en, m_irqen, m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [3:0] a, input logic [3:0] s, input logic [31:0] wd,
                     output logic [31:0] rd);
    int k;
    @(negedge clk);
    select = 1'b1; addr = a; wstrb = s; data_i = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 8);
    check("ready_latency", k, 1);
    check("ready_seen", 32'(ready), 32'd1);
    rd = data_o;
    select = 1'b0; wstrb = '0; data_i = '0;
    @(negedge clk);
    check("ready_one_cycle", 32'(ready), 32'd0);
    check("data_o_idle_zero", data_o, 32'd0);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'h0, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    logic [31:0] r;
    bus(a, 4'h1, v, r);
    check("write_data_o", r, 32'd0);
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    wait_cyc(4);
    spi_clk = 1'b1;
    wait_cyc(4);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_high();
    wait_cyc(4);
    spi_cs = 1'b1;
    wait_cyc(6);
  endtask

  function automatic logic [31:0] m_status();
    logic [4:0] c;
    c = 5'(mq.size());
    return {23'b0, c, 1'b0, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          op, nb, np;

    reset = 1'b1; select = 1'b0; wstrb = '0; addr = '0; data_i = '0;
    spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;

    tbl[0]  = '{4'h0, 4'h0, 32'h0,        32'h0};
    tbl[1]  = '{4'h4, 4'h0, 32'h0,        32'h0};
    tbl[2]  = '{4'h8, 4'h0, 32'h0,        32'h0};
    tbl[3]  = '{4'hC, 4'h0, 32'h0,        32'h0};
    tbl[4]  = '{4'h0, 4'h1, 32'h3,        32'h0};
    tbl[5]  = '{4'h0, 4'h0, 32'h0,        32'h3};
    tbl[6]  = '{4'h0, 4'hE, 32'h0,        32'h0};
    tbl[7]  = '{4'h0, 4'h0, 32'h0,        32'h3};
    tbl[8]  = '{4'hC, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{4'hC, 4'h0, 32'h0,        32'h0};
    tbl[10] = '{4'h4, 4'h1, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{4'h4, 4'h0, 32'h0,        32'h0};
    tbl[12] = '{4'h0, 4'h1, 32'hFFFFFFFC, 32'h0};
    tbl[13] = '{4'h0, 4'h0, 32'h0,        32'h0};

    wait_cyc(3);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_data_o", data_o, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    wait_cyc(2);

    for (int i = 0; i < 14; i++) begin
      bus(tbl[i].a, tbl[i].s, tbl[i].wd, r);
      check($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    // Single byte frame
    wr(4'h0, 32'h1);
    cs_low(); spi_byte(8'hA5); cs_high();
    rd_chk("a5_status", 4'h4, 32'h11);
    rd_chk("a5_data", 4'h8, 32'hA5);
    rd_chk("a5_status_after", 4'h4, 32'h0);

    // Overrun with five bytes into a four-deep FIFO
    wr(4'h0, 32'h3);
    cs_low();
    for (int i = 1; i <= 5; i++) spi_byte(8'(i * 8'h11));
    cs_high();
    rd_chk("ovr_status", 4'h4, 32'h47);
    check("ovr_irq", 32'(irq), 32'd1);
    for (int i = 1; i <= 4; i++) rd_chk("ovr_data", 4'h8, 32'(i * 8'h11));
    rd_chk("ovr_status_empty", 4'h4, 32'h4);
    check("ovr_irq_still", 32'(irq), 32'd1);
    wr(4'h4, 32'h4);
    rd_chk("ovr_cleared", 4'h4, 32'h0);
    check("ovr_irq_clear", 32'(irq), 32'd0);

    // Partial byte discarded
    wr(4'h0, 32'h1);
    cs_low();
    spi_bit(1); spi_bit(0); spi_bit(1); spi_bit(1); spi_bit(0);
    cs_high();
    rd_chk("partial_status", 4'h4, 32'h0);
    cs_low(); spi_byte(8'h3C); cs_high();
    rd_chk("partial_status2", 4'h4, 32'h11);
    rd_chk("partial_data", 4'h8, 32'h3C);

    // Push and pop in the same cycle on a full FIFO
    cs_low();
    for (int i = 1; i <= 4; i++) spi_byte(8'(i));
    cs_high();
    rd_chk("full_status", 4'h4, 32'h43);
    cs_low();
    b = 8'h99;
    for (int i = 7; i >= 1; i--) spi_bit(b[i]);
    spi_mosi = b[0];
    wait_cyc(4);
    spi_clk = 1'b1;
    @(negedge clk);
    select = 1'b1; addr = 4'h8; wstrb = 4'h0;
    @(negedge clk);
    check("collide_ready", 32'(ready), 32'd1);
    check("collide_data", data_o, 32'h01);
    select = 1'b0;
    @(negedge clk);
    check("collide_ready_low", 32'(ready), 32'd0);
    wait_cyc(2);
    spi_clk = 1'b0;
    cs_high();
    rd_chk("collide_status", 4'h4, 32'h43);
    rd_chk("collide_d2", 4'h8, 32'h02);
    rd_chk("collide_d3", 4'h8, 32'h03);
    rd_chk("collide_d4", 4'h8, 32'h04);
    rd_chk("collide_new", 4'h8, 32'h99);
    rd_chk("collide_empty", 4'h4, 32'h0);

    // EN cleared mid-frame; FSM must wait for a fresh cs fall
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit(1);
    wr(4'h0, 32'h0);
    for (int i = 0; i < 4; i++) spi_bit(1);
    wr(4'h0, 32'h1);
    spi_byte(8'hFF);
    cs_high();
    rd_chk("en_off_status", 4'h4, 32'h0);
    cs_low(); spi_byte(8'h5A); cs_high();
    rd_chk("en_back_data", 4'h8, 32'h5A);

    // Reset mid-byte
    wr(4'h0, 32'h3);
    cs_low(); spi_byte(8'h77); cs_high();
    check("prereset_irq", 32'(irq), 32'd1);
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit(1);
    reset = 1'b1;
    wait_cyc(2);
    check("midreset_ready", 32'(ready), 32'd0);
    check("midreset_data_o", data_o, 32'd0);
    check("midreset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1);
    cs_high();
    rd_chk("postreset_status", 4'h4, 32'h0);
    rd_chk("postreset_ctrl", 4'h0, 32'h0);
    check("postreset_irq", 32'(irq), 32'd0);

    // Random traffic against the queue model
    mq.delete(); m_en = 0; m_irqen = 0; m_ovr = 0;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        nb = $urandom_range(0, 3);
        np = $urandom_range(0, 7);
        cs_low();
        for (int j = 0; j < nb; j++) begin
          b = 8'($urandom);
          spi_byte(b);
          if (m_en) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovr = 1;
          end
        end
        for (int j = 0; j < np; j++) spi_bit(1'($urandom));
        cs_high();
      end else if (op <= 5) begin
        rd_chk("rnd_data", 4'h8, (mq.size() != 0) ? 32'(mq.pop_front()) : 32'h0);
      end else if (op == 6) begin
        rd_chk("rnd_status", 4'h4, m_status());
      end else if (op == 7) begin
        m_en    = ($urandom_range(0, 3) != 0);
        m_irqen = 1'($urandom);
        wr(4'h0, {30'($urandom), m_irqen, m_en});
      end else if (op == 8) begin
        r = $urandom;
        wr(4'h4, r);
        if (r[2]) m_ovr = 0;
      end else begin
        rd_chk("rnd_ctrl", 4'h0, {30'b0, m_irqen, m_en});
      end
      check("rnd_irq", 32'(irq), 32'(m_irqen & ((mq.size() != 0) | m_ovr)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
